// File: rtl/gpc_pkg.sv
// Shared GPU-core package.
// Holds the access-size encodings used across the load/store path and a
// helper that decides whether a (size, low address bits) pair is illegal.
package gpc_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // 1 when the access cannot be served: reserved size or misaligned address.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] alo);
        logic e;
        case (size)
            SIZE_B:  e = 1'b0;
            SIZE_H:  e = alo[0];
            SIZE_W:  e = (alo != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
//   size, uns, alo : access size, zero-extend select, address bits [1:0]
//   word           : word captured from memory
//   wdata          : right-aligned store data
//   ld_data        : extracted and extended load result
//   st_data        : captured word with the addressed lane(s) replaced
// Little-endian: byte lane = alo, half lane = alo[1].
module lsu_align
    import gpc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       size,
    input  logic             uns,
    input  logic [1:0]       alo,
    input  logic [WIDTH-1:0] word,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] st_data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b       = word[{alo, 3'b000} +: 8];
        h       = word[{alo[1], 4'b0000} +: 16];
        ld_data = word;
        st_data = word;
        case (size)
            SIZE_B: begin
                ld_data = {{(WIDTH-8){~uns & b[7]}}, b};
                st_data[{alo, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                ld_data = {{(WIDTH-16){~uns & h[15]}}, h};
                st_data[{alo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request in flight, single-cycle memory read port and
// full-word write port. Sub-word stores are read-modify-write (RD then WR).
//   req_*  : request handshake and fields (accepted in IDLE only)
//   resp_* : response handshake; rdata is 0 for stores and errors
//   mem_*  : memory ports; addresses/data are 0 whenever their strobe is 0
// rst is synchronous, active low; every output is forced to 0 while it is low.
module lsu
    import gpc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wen,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_ren,
    output logic [WIDTH-1:0] mem_raddr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_wen,
    output logic [WIDTH-1:0] mem_waddr,
    output logic [WIDTH-1:0] mem_wdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    typedef struct packed {
        logic             wen;
        logic [1:0]       size;
        logic             uns;
        logic             err;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] wdata;
    } req_t;

    state_t           state_q, state_d;
    req_t             req_q;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] ld_data, st_data;
    logic [WIDTH-1:0] waligned;
    logic             new_err;

    assign new_err  = access_err(req_size, req_addr[1:0]);
    assign waligned = {req_q.addr[WIDTH-1:2], 2'b00};

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .size    (req_q.size),
        .uns     (req_q.uns),
        .alo     (req_q.addr[1:0]),
        .word    (word_q),
        .wdata   (req_q.wdata),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_ren    = 1'b0;
        mem_raddr  = '0;
        mem_wen    = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        // Gate on rst so outputs drop to 0 in the same cycle reset is seen.
        if (rst) begin
            case (state_q)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (new_err)                             state_d = RESP;
                        else if (!req_wen || req_size != SIZE_W) state_d = RD;
                        else                                     state_d = WR;
                    end
                end
                RD: begin
                    mem_ren   = 1'b1;
                    mem_raddr = waligned;
                    state_d   = req_q.wen ? WR : RESP;
                end
                WR: begin
                    mem_wen   = 1'b1;
                    mem_waddr = waligned;
                    mem_wdata = (req_q.size == SIZE_W) ? req_q.wdata : st_data;
                    state_d   = RESP;
                end
                RESP: begin
                    resp_valid = 1'b1;
                    resp_err   = req_q.err;
                    resp_rdata = (req_q.err || req_q.wen) ? '0 : ld_data;
                    if (resp_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            req_q  <= '0;
            word_q <= '0;
        end else begin
            if (req_valid && req_ready) begin
                req_q.wen   <= req_wen;
                req_q.size  <= req_size;
                req_q.uns   <= req_unsigned;
                req_q.err   <= new_err;
                req_q.addr  <= req_addr;
                req_q.wdata <= req_wdata;
            end
            if (state_q == RD) word_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, read-modify-write / backpressure /
// reset-abort sequences, then randomized traffic against a byte-array model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wen, req_unsigned, resp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, mem_ren, mem_wen;
    logic [31:0] resp_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;

    always #5 clk = ~clk;

    lsu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    // Memory: 256 words, combinational read, write on rising edge.
    logic [31:0] mem [0:255];
    logic        init_we;
    logic [7:0]  init_idx;
    logic [31:0] init_val;

    assign mem_rdata = mem[mem_raddr[9:2]];

    always @(posedge clk) begin
        if (init_we)      mem[init_idx] <= init_val;
        else if (mem_wen) mem[mem_waddr[9:2]] <= mem_wdata;
    end

    // Reference model: flat byte array.
    logic [7:0] ref_b [0:1023];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        return (addr % (32'd1 << size)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr);
        int n = 1 << size;
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_b[int'(addr[9:0]) + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
        int n = 1 << size;
        for (int i = 0; i < n; i++) ref_b[int'(addr[9:0]) + i] = 8'(wdata >> (8 * i));
    endtask

    function automatic int model_lat(input logic wen, input logic [1:0] size, input logic [31:0] addr);
        if (model_err(size, addr)) return 1;
        if (!wen || size == 2'd2) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] ref_word(input int widx);
        return {ref_b[widx*4+3], ref_b[widx*4+2], ref_b[widx*4+1], ref_b[widx*4]};
    endfunction

    function automatic logic outs_any();
        return |{req_ready, resp_valid, resp_rdata, resp_err, mem_ren, mem_raddr,
                 mem_wen, mem_waddr, mem_wdata};
    endfunction

    // Issue one request at a negedge; returns latency, strobe counts and the
    // last seen memory addresses/data. hold = cycles resp_ready stays low.
    task automatic run_req(input logic wen, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int nren, output int nwen, output logic [31:0] wd,
                           output logic [31:0] wa, output logic [31:0] ra);
        lat = 0; nren = 0; nwen = 0; wd = 0; wa = 0; ra = 0; rdata = 0; err = 0;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_ren) begin nren++; ra = mem_raddr; end
            else chk("raddr_zero", mem_raddr, 32'd0);
            if (mem_wen) begin nwen++; wa = mem_waddr; wd = mem_wdata; end
            else begin
                chk("waddr_zero", mem_waddr, 32'd0);
                chk("wdata_zero", mem_wdata, 32'd0);
            end
            if (resp_valid) begin lat = k; break; end
        end
        if (lat == 0) begin
            chk("resp_timeout", 32'd0, 32'd1);
            return;
        end
        rdata = resp_rdata;
        err   = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, rdata);
            chk("hold_err", 32'(resp_err), 32'(err));
            chk("hold_ready_low", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("back_idle_ready", 32'(req_ready), 32'd1);
        chk("back_idle_valid", 32'(resp_valid), 32'd0);
    endtask

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_ren;
        int          exp_wen;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] rd, wd, wa, ra;
        logic        er;
        int          lat, nren, nwen;

        vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'hFFFF_FF88, 1'b0, 2, 1, 0, 32'h0};
        vecs[1]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'h0000_8899, 1'b0, 2, 1, 0, 32'h0};
        vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h100, 32'h0,        32'hFFFF_AABB, 1'b0, 2, 1, 0, 32'h0};
        vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h101, 32'h5A,       32'h0,         1'b0, 3, 1, 1, 32'h8899_5ABB};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h8899_5ABB, 1'b0, 2, 1, 0, 32'h0};
        vecs[6]  = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h101, 32'h1111,     32'h0,         1'b1, 1, 0, 0, 32'h0};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0,         1'b0, 2, 0, 1, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'h107, 32'h0,        32'h0000_00DE, 1'b0, 2, 1, 0, 32'h0};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h106, 32'h1234ABCD, 32'h0,         1'b0, 3, 1, 1, 32'hABCD_BEEF};
        vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h106, 32'h0,        32'hFFFF_ABCD, 1'b0, 2, 1, 0, 32'h0};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h100, 32'h0,        32'hFFFF_FFBB, 1'b0, 2, 1, 0, 32'h0};

        rst = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 0; req_wdata = 0; resp_ready = 1'b0;
        init_we = 1'b0; init_idx = 0; init_val = 0;

        // Hold reset while loading memory and the model with the same contents.
        @(negedge clk);
        chk("reset_outs_zero", 32'(outs_any()), 32'd0);
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = (i == 'h40) ? 32'h8899_AABB : $urandom;
            init_we = 1'b1; init_idx = 8'(i); init_val = w;
            for (int b = 0; b < 4; b++) ref_b[i*4+b] = 8'(w >> (8 * b));
            @(negedge clk);
        end
        init_we = 1'b0;
        chk("reset_outs_zero_late", 32'(outs_any()), 32'd0);
        rst = 1'b1;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Directed table; first vector also exercises a 3-cycle backpressure hold.
        for (int i = 0; i < 13; i++) begin
            run_req(vecs[i].wen, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    (i == 0) ? 3 : i % 3, rd, er, lat, nren, nwen, wd, wa, ra);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_nren", i), 32'(nren), 32'(vecs[i].exp_ren));
            chk($sformatf("v%0d_nwen", i), 32'(nwen), 32'(vecs[i].exp_wen));
            if (vecs[i].exp_ren != 0)
                chk($sformatf("v%0d_raddr", i), ra, vecs[i].addr & 32'hFFFF_FFFC);
            if (vecs[i].exp_wen != 0) begin
                chk($sformatf("v%0d_waddr", i), wa, vecs[i].addr & 32'hFFFF_FFFC);
                chk($sformatf("v%0d_wdata", i), wd, vecs[i].exp_wdata);
            end
            if (vecs[i].wen && !model_err(vecs[i].size, vecs[i].addr))
                model_store(vecs[i].size, vecs[i].addr, vecs[i].wdata);
        end

        // Reset during RD of a half store: no write, no response.
        req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h102; req_wdata = 32'h7777;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_rd", 32'(mem_ren), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_outs_zero", 32'(outs_any()), 32'd0);
        @(negedge clk);
        chk("abort_outs_zero2", 32'(outs_any()), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_no_wen", 32'(mem_wen), 32'd0);
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        chk("abort_mem_intact", mem[8'h40], ref_word('h40));

        // Randomized traffic against the byte model.
        for (int i = 0; i < 300; i++) begin
            logic        w, u;
            logic [1:0]  s;
            logic [31:0] a, d, exp;
            logic        e;
            w = 1'($urandom);
            u = 1'($urandom);
            s = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0 && s != 2'd3) a = a & ~((32'd1 << s) - 1);
            d = $urandom;
            e = model_err(s, a);
            exp = (w || e) ? 32'd0 : model_load(s, u, a);
            run_req(w, s, u, a, d, $urandom_range(0, 2), rd, er, lat, nren, nwen, wd, wa, ra);
            chk("rnd_rdata", rd, exp);
            chk("rnd_err", 32'(er), 32'(e));
            chk("rnd_lat", 32'(lat), 32'(model_lat(w, s, a)));
            chk("rnd_nwen", 32'(nwen), 32'((w && !e) ? 1 : 0));
            chk("rnd_nren", 32'(nren), 32'((!e && (!w || s != 2'd2)) ? 1 : 0));
            if (w && !e) model_store(s, a, d);
        end

        // Final sweep: memory contents must equal the model.
        for (int i = 0; i < 256; i++) chk($sformatf("final_mem_%0d", i), mem[i], ref_word(i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the address and data width; only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low (0 = reset), sampled on rising clk.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted when req_valid & req_ready.
REQ-006 req_wen  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  encoding: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  load zero-extension select (1 = zero-extend, 0 = sign-extend).
REQ-009 req_addr  input  WIDTH  byte address.
REQ-010 req_wdata  input  WIDTH  store data, right-aligned.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  response consumed when resp_valid & resp_ready.
REQ-013 resp_rdata  output  WIDTH  load result; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned or illegal-size request.
REQ-015 mem_ren / mem_raddr / mem_rdata  output 1 / output WIDTH / input WIDTH  connect to memory read port A; memory read data is combinational, valid in the same cycle as the address.
REQ-016 mem_wen / mem_waddr / mem_wdata  output 1 / output WIDTH / output WIDTH  connect to memory write port 1; full-word write, committed on the rising edge.

Function
REQ-017 SHALL implement FSM states IDLE, RD, WR and RESP; req_ready SHALL be 1 only in IDLE, and there SHALL be at most one request in flight.
REQ-018 On acceptance, the block SHALL latch all request fields.
- A request with size 11, a half access with addr[0]=1, or a word access with addr[1:0]!=0 SHALL go IDLE->RESP with resp_err=1.
- Any load, or a byte or half store, SHALL go IDLE->RD.
- A word store SHALL go IDLE->WR.
REQ-019 RD SHALL last exactly 1 cycle.
- mem_ren=1, mem_raddr={addr[WIDTH-1:2],2'b00}, mem_rdata captured at cycle end.
- Next state: load->RESP; store->WR.
REQ-020 WR SHALL last exactly 1 cycle, with mem_wen=1 and mem_waddr as the aligned word address.
- mem_wdata for a word store SHALL be req_wdata.
- For a byte or half store, mem_wdata SHALL be the captured word with the addressed lane(s) replaced by req_wdata[7:0] or [15:0] (little-endian, byte lane = addr[1:0]).
- Next state: RESP.
REQ-021 Load data SHALL be extracted from the captured word: byte lane addr[1:0] or half lane addr[1]; it SHALL be sign- or zero-extended per req_unsigned, and a word load SHALL be passed through unchanged.
REQ-022 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until resp_ready=1; on that cycle the FSM SHALL return to IDLE.
REQ-023 Latency from the acceptance cycle T to the first resp_valid cycle SHALL be:
- error: T+1;
- load or word store: T+2;
- byte or half store: T+3.
REQ-024 mem_ren and mem_wen SHALL be 0 outside RD and WR respectively, and SHALL never be asserted for an error request.
REQ-025 mem_raddr, mem_waddr and mem_wdata SHALL be driven to 0 when their strobe is 0.

Reset
REQ-026 While rst=0, the FSM SHALL enter IDLE, all outputs SHALL be 0 (including req_ready), and latched fields and the captured word SHALL clear to 0.
REQ-027 Reset asserted in any state, including RD of a sub-word store, SHALL abort the request with no subsequent mem_wen and no response; req_ready SHALL be 1 in the first cycle after rst returns to 1.

Structure
REQ-028 The size encodings (SIZE_B=00, SIZE_H=01, SIZE_W=10) SHALL live in the shared package gpc_pkg; the FSM state encoding SHALL remain local to lsu.
REQ-029 Lane extract/extend and store merge SHALL be a combinational sub-module, lsu_align, instantiated once in lsu.

Verification
REQ-030 Memory word 0x100=0x8899AABB; signed byte load at 0x103 -> resp_rdata=0xFFFFFF88, resp_err=0, resp_valid at T+2.
REQ-031 Same memory; unsigned half load at 0x102 -> resp_rdata=0x00008899; signed half load at 0x100 -> 0xFFFFAABB.
REQ-032 Byte store of 0x5A at 0x101 -> mem_ren at T+1 (addr 0x100), mem_wen at T+2 with mem_wdata=0x88995ABB, resp_valid at T+3 with resp_rdata=0.
REQ-033 Word load at 0x102 -> resp_err=1, resp_rdata=0, resp_valid at T+1; mem_ren and mem_wen stay 0 throughout.
REQ-034 resp_ready held 0 for 3 cycles after resp_valid -> response fields stable and req_ready=0; resp_ready=1 -> IDLE, and the next request is accepted on the following cycle.
REQ-035 rst=0 during RD of a half store -> no mem_wen ever, all outputs 0, req_ready=1 in the cycle after reset release.
